// File: rtl/rib_timer_pkg.sv
// rib_timer_pkg: register offsets, CTRL layout and reset constants shared by the timer files
package rib_timer_pkg;
  localparam logic [7:0] TIMER_CTRL     = 8'h00;
  localparam logic [7:0] TIMER_COUNT    = 8'h04;
  localparam logic [7:0] TIMER_VALUE    = 8'h08;
  localparam logic [7:0] TIMER_PRESCALE = 8'h0C;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_INT_EN = 1;
  localparam int CTRL_PEND   = 2;
  localparam int CTRL_MODE   = 3;
  typedef struct packed {
    logic mode;
    logic pend;
    logic int_en;
    logic en;
  } ctrl_t;
  localparam ctrl_t       CTRL_RST = '0;
  localparam logic [31:0] WORD_RST = '0;
endpackage

// File: rtl/rib_timer_if.sv
// rib_timer_if: RIB slave-side bus plus the timer interrupt line
interface rib_timer_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        we_i;
  logic        int_sig_o;
  modport master (output addr_i, data_i, we_i, input data_o, int_sig_o);
  modport slave  (input addr_i, data_i, we_i, output data_o, int_sig_o);
endinterface

// File: rtl/rib_timer_prescaler.sv
// rib_timer_prescaler: counts 0..i_prescale while enabled, ticking on the terminal count
module rib_timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);
  logic [PRESCALE_W-1:0] r_pc;
  logic                  w_wrap;
  assign w_wrap = r_pc == i_prescale;
  assign o_tick = i_en & w_wrap;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_pc <= '0;
    else      r_pc <= (i_clr || !i_en || w_wrap) ? '0 : r_pc + 1'b1;
endmodule

// File: rtl/rib_timer.sv
// rib_timer: memory-mapped prescaled up-counter with compare match and level interrupt
module rib_timer
  import rib_timer_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int OFFSET_W   = 8
) (
  input  logic clk,
  input  logic rst,
  rib_timer_if.slave bus
);
  ctrl_t                 r_ctrl;
  logic [31:0]           r_count, r_value;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [OFFSET_W-1:0]   w_off;
  logic                  w_wr_ctrl, w_wr_count, w_wr_value, w_wr_prescale;
  logic                  w_tick, w_match, w_pc_clr, w_unused_addr;
  assign w_off         = bus.addr_i[OFFSET_W-1:0];
  assign w_unused_addr = &{1'b0, bus.addr_i[31:OFFSET_W]};
  assign w_wr_ctrl     = bus.we_i && w_off == OFFSET_W'(TIMER_CTRL);
  assign w_wr_count    = bus.we_i && w_off == OFFSET_W'(TIMER_COUNT);
  assign w_wr_value    = bus.we_i && w_off == OFFSET_W'(TIMER_VALUE);
  assign w_wr_prescale = bus.we_i && w_off == OFFSET_W'(TIMER_PRESCALE);
  assign w_pc_clr      = w_wr_prescale || (w_wr_ctrl && !bus.data_i[CTRL_EN]);
  // VALUE=0 never matches, letting the counter free-run and wrap
  assign w_match = w_tick && r_value != '0 && r_count == r_value - 32'd1;
  rib_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .i_en       (r_ctrl.en),
    .i_clr      (w_pc_clr),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ctrl     <= CTRL_RST;
      r_count    <= WORD_RST;
      r_value    <= WORD_RST;
      r_prescale <= '0;
    end else begin
      r_ctrl.en     <= w_wr_ctrl ? bus.data_i[CTRL_EN] : (w_match && !r_ctrl.mode) ? 1'b0 : r_ctrl.en;
      r_ctrl.int_en <= w_wr_ctrl ? bus.data_i[CTRL_INT_EN] : r_ctrl.int_en;
      r_ctrl.mode   <= w_wr_ctrl ? bus.data_i[CTRL_MODE] : r_ctrl.mode;
      r_ctrl.pend   <= w_match || (r_ctrl.pend && !(w_wr_ctrl && bus.data_i[CTRL_PEND]));
      r_count       <= w_wr_count ? bus.data_i : w_match ? '0 : w_tick ? r_count + 32'd1 : r_count;
      r_value       <= w_wr_value ? bus.data_i : r_value;
      r_prescale    <= w_wr_prescale ? bus.data_i[PRESCALE_W-1:0] : r_prescale;
    end
  assign bus.int_sig_o = r_ctrl.pend & r_ctrl.int_en;
  assign bus.data_o = w_off == OFFSET_W'(TIMER_CTRL)     ? {28'd0, r_ctrl} :
                      w_off == OFFSET_W'(TIMER_COUNT)    ? r_count :
                      w_off == OFFSET_W'(TIMER_VALUE)    ? r_value :
                      w_off == OFFSET_W'(TIMER_PRESCALE) ? 32'(r_prescale) :
                      WORD_RST;
endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: directed register-level checks of rib_timer against hand-computed timing
module tb_rib_timer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  rib_timer_if bus ();
  rib_timer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr_i = a;
    #1;
    chk(tag, bus.data_o, exp);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr_i = a;
    bus.data_i = d;
    bus.we_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.we_i   = 1'b0;
    bus.addr_i = '0;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.addr_i = '0;
    bus.data_i = '0;
    bus.we_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    rchk("rst_ctrl", 32'h00, 0);
    rchk("rst_count", 32'h04, 0);
    rchk("rst_value", 32'h08, 0);
    rchk("rst_presc", 32'h0C, 0);
    rchk("rst_hole", 32'h40, 0);
    chk("rst_int", {31'd0, bus.int_sig_o}, 0);
    wr(32'h10, 32'hFFFF_FFFF);
    rchk("hole_wr", 32'h10, 0);
    // periodic: PRESCALE=1, VALUE=3 -> match 6 edges after enabling
    wr(32'h0C, 1);
    wr(32'h08, 3);
    rchk("alias", 32'h108, 3);
    rchk("presc_rd", 32'h0C, 1);
    wr(32'h00, 32'hB);
    step(2);
    rchk("per_cnt1", 32'h04, 1);
    step(2);
    rchk("per_cnt2", 32'h04, 2);
    chk("per_int_lo", {31'd0, bus.int_sig_o}, 0);
    step(2);
    chk("per_int_hi", {31'd0, bus.int_sig_o}, 1);
    rchk("per_cnt0", 32'h04, 0);
    rchk("per_ctrl", 32'h00, 32'hF);
    wr(32'h00, 32'hF);
    chk("w1c_int", {31'd0, bus.int_sig_o}, 0);
    rchk("w1c_ctrl", 32'h00, 32'hB);
    step(4);
    chk("per2_lo", {31'd0, bus.int_sig_o}, 0);
    step(1);
    chk("per2_hi", {31'd0, bus.int_sig_o}, 1);
    // one-shot: PRESCALE=0, VALUE=4 -> match after 4 edges, EN self-clears
    wr(32'h00, 32'h4);
    wr(32'h0C, 0);
    wr(32'h08, 4);
    wr(32'h04, 0);
    wr(32'h00, 32'h3);
    step(3);
    chk("os_int_lo", {31'd0, bus.int_sig_o}, 0);
    step(1);
    chk("os_int_hi", {31'd0, bus.int_sig_o}, 1);
    rchk("os_ctrl", 32'h00, 32'h6);
    step(5);
    rchk("os_hold", 32'h04, 0);
    // CTRL write landing on a one-shot match: pend set wins, written EN wins
    wr(32'h00, 32'h4);
    rchk("clr_ctrl", 32'h00, 0);
    wr(32'h00, 32'h3);
    step(3);
    rchk("col_cnt3", 32'h04, 3);
    wr(32'h00, 32'h7);
    rchk("col_ctrl", 32'h00, 32'h7);
    chk("col_int", {31'd0, bus.int_sig_o}, 1);
    rchk("col_cnt0", 32'h04, 0);
    // COUNT write landing on a match overrides the reset-to-zero
    wr(32'h00, 32'h7);
    rchk("col2_ctrl", 32'h00, 32'h3);
    step(2);
    wr(32'h04, 32'h10);
    rchk("col2_cnt", 32'h04, 32'h10);
    rchk("col2_pend", 32'h00, 32'h6);
    step(2);
    rchk("col2_hold", 32'h04, 32'h10);
    // wrap with compare disabled
    wr(32'h00, 32'h4);
    wr(32'h08, 0);
    wr(32'h04, 32'hFFFF_FFFE);
    wr(32'h00, 32'h1);
    step(1);
    rchk("wrap_max", 32'h04, 32'hFFFF_FFFF);
    step(1);
    rchk("wrap_zero", 32'h04, 0);
    rchk("wrap_pend", 32'h00, 32'h1);
    // async reset between edges while counting state is live
    wr(32'h00, 32'h4);
    wr(32'h08, 3);
    wr(32'h04, 0);
    wr(32'h00, 32'h3);
    step(4);
    wr(32'h04, 5);
    chk("pre_int", {31'd0, bus.int_sig_o}, 1);
    rchk("pre_cnt", 32'h04, 5);
    #1 rst = 1'b0;
    #1;
    chk("ar_int", {31'd0, bus.int_sig_o}, 0);
    rchk("ar_ctrl", 32'h00, 0);
    rchk("ar_count", 32'h04, 0);
    rchk("ar_value", 32'h08, 0);
    rchk("ar_presc", 32'h0C, 0);
    @(negedge clk) rst = 1'b1;
    step(2);
    rchk("post_cnt", 32'h04, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
